kband_burst_writer: RTL and testbench
=====================================

# kband_burst_writer

Avalon-MM burst write master that drains the 128-bit result stream produced by the K-band output stage and writes it into HPS SDRAM. It sits directly downstream of the KBand result interface and drives the same 128-bit, 30-bit-address, 5-bit-burstcount master port type as `m0`. An internal FIFO absorbs back-pressure. Bursts are issued only when a full burst's worth of data is buffered, so `m0_write` never bubbles mid-burst.

## Interface
- `DATA_W`, 128, stream and Avalon data width (bytes per beat = DATA_W/8)
- `ADDR_W`, 30, Avalon byte address width
- `BURST_MAX`, 16, maximum beats per burst (≤ 16, fits 5-bit burstcount)
- `FIFO_DEPTH`, 32, FIFO entries; power of two, ≥ BURST_MAX
- `clk_clk`  in  1  single clock
- `reset_reset_n`  in  1  synchronous, active-low reset
- `cfg_start`  in  1  one-cycle pulse; latches config and starts a transfer
- `cfg_base_addr`  in  ADDR_W  byte start address, DATA_W/8-aligned
- `cfg_num_words`  in  24  number of DATA_W words to write
- `irq_clear`  in  1  clears `done_irq`
- `busy`  out  1  transfer in progress
- `done_irq`  out  1  sticky completion interrupt
- `snk_data`  in  DATA_W  result word from K-band output stage
- `snk_valid`  in  1  `snk_data` valid
- `snk_ready`  out  1  word accepted when `snk_valid && snk_ready`
- `m0_address`  out  ADDR_W  burst byte address
- `m0_burstcount`  out  5  beats in current burst
- `m0_writedata`  out  DATA_W  write data
- `m0_write`  out  1  write request
- `m0_byteenable`  out  DATA_W/8  always all ones
- `m0_waitrequest`  in  1  slave stall

## Operation
- FSM states: IDLE, WAIT_DATA, BURST, DONE.
- IDLE: on `cfg_start`, latch address and count into `addr_q` and `words_left`. Also latch count into `in_left`, which tracks words still to accept from the stream.
  - If count = 0, go to DONE.
  - Otherwise go to WAIT_DATA.
- `cfg_start` outside IDLE is ignored.
- `snk_ready` = `busy && in_left != 0 && fifo not full`. Each accepted word decrements `in_left` and is pushed into the FIFO.
- WAIT_DATA: compute `len = min(BURST_MAX, words_left)`. When FIFO level ≥ `len`, load `beats = len` and go to BURST.
- BURST:
  - `m0_write` = 1.
  - `m0_address` and `m0_burstcount` are held constant for the whole burst.
  - `m0_writedata` = FIFO head.
  - A beat completes on `m0_write && !m0_waitrequest`. Each completed beat pops the FIFO and decrements `beats` and `words_left`.
  - On the last beat, `addr_q += len * DATA_W/8`. If `words_left` becomes 0, go to DONE; otherwise go to WAIT_DATA.
- DONE: set `done_irq` and go to IDLE on the next cycle.
- `busy` is 1 in WAIT_DATA, BURST and DONE.
- `done_irq` is sticky and is cleared by `irq_clear`. If set and clear occur in the same cycle, set wins.
- Push and pop in the same cycle leave the FIFO level unchanged. A full FIFO with a simultaneous pop still deasserts `snk_ready`, because readiness is computed from the registered level.
- Address arithmetic is modulo 2^ADDR_W (wrap silently, no error).
- Reset, including mid-burst: FIFO flushed, FSM to IDLE, all counters cleared.

## Timing
- Reset values of all outputs are 0: `busy`, `done_irq`, `snk_ready`, `m0_write`, `m0_address`, `m0_burstcount`, `m0_writedata`. The exception is `m0_byteenable`, which is all ones.
- `busy` rises 1 cycle after `cfg_start`.
- Stream-to-FIFO latency: a word accepted in cycle N is counted in the FIFO level in cycle N+1.
- WAIT_DATA → BURST transition: first cycle with level ≥ `len`. `m0_write` is asserted the following cycle.
- With no waitrequest, a burst of L beats takes L cycles. There is 1 WAIT_DATA cycle between bursts when the FIFO is already sufficiently full.
- `m0_write` and all m0 outputs are registered and held stable while `m0_waitrequest` = 1.
- `done_irq` rises 1 cycle after the final beat is accepted. `busy` falls on the cycle after `done_irq` rises.

## Test plan
- Single burst: base 0x1000, 16 words, continuous `snk_valid`, no waitrequest → one burst with burstcount 16 at 0x1000; data in order; `done_irq` = 1 and `busy` = 0 afterwards.
- Multi-burst with tail: base 0x0, 40 words → bursts (addr, count) = (0x000, 16), (0x100, 16), (0x200, 8). `m0_write` never deasserts inside a burst.
- Back-pressure: random `m0_waitrequest` (50%) and random `snk_valid` gaps, 100 words → all words are written exactly once, in order. Address and burstcount are stable while stalled. `snk_ready` = 0 whenever the FIFO level is 32.
- Zero length: `cfg_start` with `cfg_num_words` = 0 → no `m0_write`; `done_irq` is set within 2 cycles.
- Control edges:
  - `cfg_start` pulsed mid-transfer → ignored; the count is unchanged.
  - `irq_clear` in the same cycle `done_irq` is set → `done_irq` = 1.
  - `irq_clear` later → `done_irq` = 0.
- Reset mid-burst: deassert `reset_reset_n` during beat 5 of 16 → next cycle `m0_write` = 0, `busy` = 0, FIFO empty. A new 16-word transfer then completes correctly.

Source files
------------

// File: rtl/kband_burst_writer.sv
// Avalon-MM burst write master: buffers the K-band result stream in a FIFO and
// writes it to SDRAM in full bursts only, so m0_write never bubbles mid-burst.
module kband_burst_writer #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 30,
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [23:0]           cfg_num_words,
  input  logic                  irq_clear,
  output logic                  busy,
  output logic                  done_irq,
  input  logic [DATA_W-1:0]     snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [ADDR_W-1:0]     m0_address,
  output logic [4:0]            m0_burstcount,
  output logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_write,
  output logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_waitrequest
);

  localparam int BYTES = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [23:0]         words_left;
  logic [23:0]         in_left;
  logic [4:0]          beats;
  logic [4:0]          len;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level;
  logic                push, pop, last_beat;
  logic                start, load_burst;

  assign busy          = (state != IDLE);
  // Readiness uses the registered level, so a full FIFO stalls even when popping.
  assign snk_ready     = busy && (in_left != 24'd0) && (level != LVL_W'(FIFO_DEPTH));
  assign push          = snk_valid && snk_ready;
  assign pop           = m0_write && !m0_waitrequest;
  assign last_beat     = pop && (beats == 5'd1);
  assign len           = (words_left >= 24'(BURST_MAX)) ? 5'(BURST_MAX) : words_left[4:0];
  assign m0_byteenable = '1;
  assign m0_writedata  = m0_write ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    load_burst = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          start      = 1'b1;
          state_next = (cfg_num_words == 24'd0) ? DONE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (level >= LVL_W'(len)) begin
          load_burst = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        if (last_beat) state_next = (words_left == 24'd1) ? DONE : WAIT_DATA;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the FIFO storage is not reset; pointers and level are, which is what makes it empty.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= snk_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      addr_q        <= '0;
      words_left    <= '0;
      in_left       <= '0;
      beats         <= '0;
      m0_address    <= '0;
      m0_burstcount <= '0;
      m0_write      <= 1'b0;
      done_irq      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
    end else begin
      if (start) begin
        addr_q     <= cfg_base_addr;
        words_left <= cfg_num_words;
        in_left    <= cfg_num_words;
      end else if (push) begin
        in_left <= in_left - 24'd1;
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (load_burst) begin
        beats         <= len;
        m0_burstcount <= len;
        m0_address    <= addr_q;
        m0_write      <= 1'b1;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        beats      <= beats - 5'd1;
        words_left <= words_left - 24'd1;
      end

      // Address advance wraps modulo 2^ADDR_W by truncation.
      if (last_beat) begin
        m0_write <= 1'b0;
        addr_q   <= addr_q + ADDR_W'(m0_burstcount) * ADDR_W'(BYTES);
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      // Set has priority over clear.
      if (state_next == DONE) done_irq <= 1'b1;
      else if (irq_clear)     done_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kband_burst_writer.sv
// Self-checking bench for kband_burst_writer: a transfer-level model (expected
// word order and burst list) is compared against the Avalon master every cycle.
module tb_kband_burst_writer;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 30;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                count;
  } burst_t;

  logic                clk_clk = 1'b0;
  logic                reset_reset_n;
  logic                cfg_start;
  logic [ADDR_W-1:0]   cfg_base_addr;
  logic [23:0]         cfg_num_words;
  logic                irq_clear;
  logic                busy;
  logic                done_irq;
  logic [DATA_W-1:0]   snk_data;
  logic                snk_valid;
  logic                snk_ready;
  logic [ADDR_W-1:0]   m0_address;
  logic [4:0]          m0_burstcount;
  logic [DATA_W-1:0]   m0_writedata;
  logic                m0_write;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic                m0_waitrequest;

  kband_burst_writer dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .irq_clear      (irq_clear),
    .busy           (busy),
    .done_irq       (done_irq),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .m0_address     (m0_address),
    .m0_burstcount  (m0_burstcount),
    .m0_writedata   (m0_writedata),
    .m0_write       (m0_write),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_words[$];
  burst_t            exp_bursts[$];
  burst_t            burst_log[$];
  int                level_m    = 0;
  int                beat_cnt   = 0;
  int                done_stage = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      level_m    = 0;
      beat_cnt   = 0;
      done_stage = 0;
      exp_words.delete();
      exp_bursts.delete();
    end else begin
      check("byteenable", 128'(m0_byteenable), 128'hFFFF);
      if (done_stage == 1) begin
        check("done_irq_after_last_beat", 128'(done_irq), 128'd1);
        check("busy_during_done", 128'(busy), 128'd1);
        done_stage = 2;
      end else if (done_stage == 2) begin
        check("busy_fall_after_done", 128'(busy), 128'd0);
        done_stage = 0;
      end
      if (level_m == 32) check("ready_low_when_full", 128'(snk_ready), 128'd0);
      if (m0_write) begin
        if (exp_bursts.size() == 0 || exp_words.size() == 0) begin
          check("unexpected_write", 128'(m0_write), 128'd0);
        end else begin
          check("m0_address", 128'(m0_address), 128'(exp_bursts[0].addr));
          check("m0_burstcount", 128'(m0_burstcount), 128'(exp_bursts[0].count));
          check("m0_writedata", m0_writedata, exp_words[0]);
          if (!m0_waitrequest) begin
            void'(exp_words.pop_front());
            beat_cnt++;
            if (beat_cnt == exp_bursts[0].count) begin
              burst_log.push_back('{addr: m0_address, count: int'(m0_burstcount)});
              void'(exp_bursts.pop_front());
              beat_cnt = 0;
              if (exp_words.size() == 0) done_stage = 1;
            end
          end
        end
      end else if (beat_cnt != 0) begin
        check("write_held_in_burst", 128'(m0_write), 128'd1);
      end
      level_m = level_m + int'(snk_valid && snk_ready) - int'(m0_write && !m0_waitrequest);
    end
  end

  // Runs one transfer. reset_beat >= 0 aborts with a reset while that beat index is presented.
  task automatic run_xfer(input logic [ADDR_W-1:0] base, input int n, input int valid_pct,
                          input int wait_pct, input int reset_beat, input bit clear_on_last,
                          input bit mid_start);
    logic [DATA_W-1:0] src[$];
    logic [ADDR_W-1:0] a;
    int rem, ln, idx, cyc;
    bit acc;
    src.delete();
    exp_words.delete();
    exp_bursts.delete();
    burst_log.delete();
    for (int i = 0; i < n; i++) begin
      src.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      exp_words.push_back(src[i]);
    end
    rem = n;
    a   = base;
    while (rem > 0) begin
      ln = (rem > 16) ? 16 : rem;
      exp_bursts.push_back('{addr: a, count: ln});
      a   = a + ADDR_W'(ln * 16);
      rem = rem - ln;
    end

    cfg_base_addr = base;
    cfg_num_words = 24'(n);
    cfg_start     = 1'b1;
    irq_clear     = 1'b1;
    @(posedge clk_clk); #1;
    cfg_start = 1'b0;
    irq_clear = 1'b0;
    check("busy_rise", 128'(busy), 128'd1);

    idx = 0;
    cyc = 0;
    forever begin
      snk_valid      = (idx < n) && ($urandom_range(99) < valid_pct);
      snk_data       = (idx < n) ? src[idx] : '0;
      m0_waitrequest = ($urandom_range(99) < wait_pct);
      irq_clear      = clear_on_last && m0_write && !m0_waitrequest && (exp_words.size() == 1);
      cfg_start      = mid_start && (cyc == 10);
      if (cfg_start) begin
        cfg_base_addr = 30'h3000;
        cfg_num_words = 24'd5;
      end
      if (reset_beat >= 0 && m0_write && (n - exp_words.size()) == reset_beat) begin
        reset_reset_n = 1'b0;
        @(posedge clk_clk); #1;
        check("rst_m0_write", 128'(m0_write), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_snk_ready", 128'(snk_ready), 128'd0);
        check("rst_writedata", m0_writedata, 128'd0);
        reset_reset_n  = 1'b1;
        snk_valid      = 1'b0;
        m0_waitrequest = 1'b0;
        irq_clear      = 1'b0;
        return;
      end
      @(negedge clk_clk);
      acc = snk_valid && snk_ready;
      @(posedge clk_clk); #1;
      if (acc) idx++;
      cyc++;
      if (!busy) break;
      if (cyc > 5000) begin
        check("xfer_timeout", 128'(busy), 128'd0);
        break;
      end
    end
    snk_valid      = 1'b0;
    m0_waitrequest = 1'b0;
    irq_clear      = 1'b0;
    cfg_start      = 1'b0;
    check("words_all_written", 128'(exp_words.size()), 128'd0);
    check("bursts_all_issued", 128'(exp_bursts.size()), 128'd0);
    check("done_irq_end", 128'(done_irq), 128'd1);
  endtask

  task automatic check_log(input int idx, input logic [ADDR_W-1:0] addr, input int count);
    if (burst_log.size() > idx) begin
      check("log_addr", 128'(burst_log[idx].addr), 128'(addr));
      check("log_count", 128'(burst_log[idx].count), 128'(count));
    end else begin
      check("log_missing", 128'(burst_log.size()), 128'(idx + 1));
    end
  endtask

  initial begin
    bit seen;
    reset_reset_n  = 1'b0;
    cfg_start      = 1'b0;
    cfg_base_addr  = '0;
    cfg_num_words  = '0;
    irq_clear      = 1'b0;
    snk_data       = '0;
    snk_valid      = 1'b0;
    m0_waitrequest = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done_irq", 128'(done_irq), 128'd0);
    check("reset_snk_ready", 128'(snk_ready), 128'd0);
    check("reset_m0_write", 128'(m0_write), 128'd0);
    check("reset_m0_address", 128'(m0_address), 128'd0);
    check("reset_m0_burstcount", 128'(m0_burstcount), 128'd0);
    check("reset_m0_writedata", m0_writedata, 128'd0);
    check("reset_byteenable", 128'(m0_byteenable), 128'hFFFF);
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Single 16-beat burst
    run_xfer(30'h1000, 16, 100, 0, -1, 1'b0, 1'b0);
    check("single_burst_count", 128'(burst_log.size()), 128'd1);
    check_log(0, 30'h1000, 16);

    // Multi-burst with tail
    run_xfer(30'h0, 40, 100, 0, -1, 1'b0, 1'b0);
    check("multi_burst_count", 128'(burst_log.size()), 128'd3);
    check_log(0, 30'h000, 16);
    check_log(1, 30'h100, 16);
    check_log(2, 30'h200, 8);

    // Back-pressure on both sides
    run_xfer(30'h2000, 100, 90, 50, -1, 1'b0, 1'b0);
    check("bp_burst_count", 128'(burst_log.size()), 128'd7);

    // Zero-length transfer
    irq_clear = 1'b1;
    @(posedge clk_clk); #1;
    irq_clear = 1'b0;
    check("irq_cleared_before_zero", 128'(done_irq), 128'd0);
    cfg_base_addr = 30'h5000;
    cfg_num_words = 24'd0;
    cfg_start     = 1'b1;
    @(posedge clk_clk); #1;
    cfg_start = 1'b0;
    seen = done_irq;
    if (!seen) begin
      @(posedge clk_clk); #1;
      seen = done_irq;
    end
    check("zero_len_done_irq", 128'(seen), 128'd1);
    repeat (2) @(posedge clk_clk);
    #1;
    check("zero_len_idle", 128'(busy), 128'd0);

    // cfg_start mid-transfer is ignored
    run_xfer(30'h500, 20, 100, 30, -1, 1'b0, 1'b1);
    check("mid_start_burst_count", 128'(burst_log.size()), 128'd2);
    check_log(1, 30'h600, 4);

    // irq_clear coincident with set, then alone
    run_xfer(30'h800, 16, 100, 0, -1, 1'b1, 1'b0);
    check("set_wins_over_clear", 128'(done_irq), 128'd1);
    irq_clear = 1'b1;
    @(posedge clk_clk); #1;
    irq_clear = 1'b0;
    check("irq_clear_later", 128'(done_irq), 128'd0);

    // Reset during beat 5 of 16, then a clean transfer
    run_xfer(30'h4000, 16, 100, 0, 4, 1'b0, 1'b0);
    @(posedge clk_clk); #1;
    run_xfer(30'h4000, 16, 100, 0, -1, 1'b0, 1'b0);
    check("post_reset_burst_count", 128'(burst_log.size()), 128'd1);
    check_log(0, 30'h4000, 16);

    repeat (3) @(posedge clk_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
